uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Round-robin scheduler that shares one uart_tx instance among NREQ byte producers (CSR writer, debug logger, DMA, ...).
- Selects a requester, latches its byte, and drives uart_tx's tx_start/tx_data.
- Completes a four-phase handshake against tx_done, which arrives from the baud clock domain and is synchronised here.
- Reports per-transfer completion status: ok, uart error or watchdog timeout.

Parameters:
NREQ, 4, number of requesters (2..16)
TIMEOUT, 262143, clk_i cycles allowed in each of SEND and RELEASE before abort; 0 disables the watchdog
SYNC_STAGES, 2, flop depth of the tx_done_i/tx_err_i synchronisers (>=2)

Ports:
clk_i  in  1  system clock; all logic on its rising edge
rst_i  in  1  asynchronous, active-low reset
en_i  in  1  1 = new grants allowed; a transfer in progress always completes
req_i  in  NREQ  per-requester request level
data_i  in  8*NREQ  byte of requester k on bits [8k+7:8k]
gnt_o  out  NREQ  one-hot, one-cycle pulse: byte of that requester accepted
busy_o  out  1  high in SEND/RELEASE
done_o  out  1  one-cycle pulse: transfer finished
done_id_o  out  clog2(NREQ)  requester index of the finished transfer; valid with done_o
done_status_o  out  2  00 ok, 01 uart error, 10 timeout; valid with done_o
tx_start_o  out  1  to uart_tx tx_start_i
tx_data_o  out  8  to uart_tx tx_data_i; held stable while tx_start_o=1
tx_done_i  in  1  from uart_tx tx_done_o (async, baud domain)
tx_err_i  in  1  from uart_tx tx_err_o (async, baud domain)

Behaviour:
- Reset values: all outputs 0, state IDLE, RR pointer last=NREQ-1 (requester 0 wins first), timer 0, synchronisers 0.
- Reset asserted mid-transfer aborts immediately with no done_o. uart_tx is reset by the same rst_i.
- Synchronisers: done_s and err_s come from SYNC_STAGES-flop chains. Requirement on uart_tx: tx_err_i must be stable from at least 1 baud clock before tx_done_i rises until tx_done_i falls.
- IDLE:
  - When en_i=1, req_i!=0 and done_s=0, choose winner w = first set bit scanning last+1, last+2, ... modulo NREQ.
  - Next cycle: gnt_o[w]=1 for exactly one cycle, tx_data_o=data_i[w], cur_id=w, last=w, tx_start_o=1, timer=0, go to SEND. Latency from req_i sampled to gnt_o is 1 cycle.
  - done_s=1 while in IDLE (stale/stuck) blocks all grants.
- SEND:
  - tx_start_o=1 and tx_data_o held; timer increments each cycle.
  - On done_s=1: status = err_s ? 01 : 00, tx_start_o=0, timer=0, go to RELEASE.
  - Else if TIMEOUT!=0 and timer==TIMEOUT-1: status=10, tx_start_o=0, timer=0, go to RELEASE.
  - done_s takes precedence over timeout in the same cycle.
- RELEASE:
  - Wait for done_s=0, then in the next cycle pulse done_o=1 with done_id_o=cur_id and the recorded status, and go to IDLE.
  - If done_s stays high until timer==TIMEOUT-1, exit the same way. Status keeps its SEND value unless that was 00, in which case it becomes 10.
- busy_o=1 in SEND and RELEASE.
- Requester contract: hold req_i and its data_i stable until gnt_o; drop req_i the cycle after gnt_o. A req_i still high after its grant re-arbitrates normally and goes behind the other pending requesters.
- Back-to-back throughput: the earliest next grant is the cycle after done_o.
- en_i falling in SEND/RELEASE does not abort; it only blocks the next grant.
- Timer width is clog2(TIMEOUT+1) and saturates; no wrap.
- req_i bits outside 0..NREQ-1 do not exist; pointer arithmetic wraps modulo NREQ (non-power-of-2 NREQ supported).

Test Plan:
1. NREQ=4, req_i=0001, data 0xA5 -> gnt_o=0001 one cycle later, tx_data_o=0xA5, tx_start_o high until model raises tx_done; after tx_done falls, done_o pulse, id 0, status 00.
2. req_i=1111 held, data 0x10/0x21/0x32/0x43 -> grants in order 0,1,2,3,0; tx_data_o sequence 10,21,32,43,10; exactly one done_o per grant.
3. Model raises tx_err_i with tx_done_i on requester 2's byte -> done_o id 2, status 01; next transfer status 00.
4. TIMEOUT=100, tx_done_i never rises -> tx_start_o falls 100 cycles after gnt_o; done_o a few cycles later, status 10; next request is still granted.
5. en_i=0 with req_i=0100 for 50 cycles -> no gnt_o; en_i=1 -> gnt_o=0100 next cycle. Separately, tx_done_i stuck at 1 in IDLE -> no grants until it drops.
6. rst_i low mid-SEND -> all outputs 0 asynchronously, no done_o; after release, req_i=1000 with last reset -> requester 3 granted and completes with status 00.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Bundle of the requester-side and uart_tx-side signals of uart_tx_arbiter.
// slave is the arbiter's view, master is the view of whoever drives the
// requesters and models uart_tx.
interface uart_tx_arbiter_if #(
  parameter int NREQ = 4
);
  localparam int IDW = $clog2(NREQ);

  logic              en_i;
  logic [NREQ-1:0]   req_i;
  logic [8*NREQ-1:0] data_i;
  logic [NREQ-1:0]   gnt_o;
  logic              busy_o;
  logic              done_o;
  logic [IDW-1:0]    done_id_o;
  logic [1:0]        done_status_o;
  logic              tx_start_o;
  logic [7:0]        tx_data_o;
  logic              tx_done_i;
  logic              tx_err_i;

  modport slave (
    input  en_i, req_i, data_i, tx_done_i, tx_err_i,
    output gnt_o, busy_o, done_o, done_id_o, done_status_o, tx_start_o, tx_data_o
  );

  modport master (
    output en_i, req_i, data_i, tx_done_i, tx_err_i,
    input  gnt_o, busy_o, done_o, done_id_o, done_status_o, tx_start_o, tx_data_o
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one uart_tx among NREQ byte producers.
// Latches the winner's byte, runs the tx_start/tx_done four-phase handshake
// against the synchronised baud-domain tx_done/tx_err, and reports a
// per-transfer status (00 ok, 01 uart error, 10 watchdog timeout).
//
// state     | meaning
// ----------+--------------------------------------------------------
// S_IDLE    | no transfer; grant when enabled, requested, done_s low
// S_SEND    | tx_start high with byte held; wait for done_s or timeout
// S_RELEASE | tx_start low; wait for done_s to drop or timeout
module uart_tx_arbiter #(
  parameter int NREQ        = 4,
  parameter int TIMEOUT     = 262143,
  parameter int SYNC_STAGES = 2
) (
  input logic              clk_i,
  input logic              rst_i,
  uart_tx_arbiter_if.slave bus
);
  localparam int IDW = $clog2(NREQ);
  // A zero TIMEOUT still needs a one-bit timer so the code stays legal.
  localparam int TW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0]  T_LAST   = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [IDW-1:0] LAST_RST = IDW'(NREQ - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SEND    = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t           state_q, state_nxt;
  logic [TW-1:0]    timer_q, timer_nxt, timer_inc;
  logic [IDW-1:0]   last_q, last_nxt;
  logic [IDW-1:0]   id_q, id_nxt;
  logic [1:0]       sts_q, sts_nxt;
  logic [NREQ-1:0]  gnt_q, gnt_nxt;
  logic             start_q, start_nxt;
  logic [7:0]       data_q, data_nxt;
  logic             done_q, done_nxt;
  logic [IDW-1:0]   done_id_q, done_id_nxt;
  logic [1:0]       done_sts_q, done_sts_nxt;
  logic             busy_q;

  logic [SYNC_STAGES-1:0] done_sync, err_sync;
  logic                   done_s, err_s;

  logic             found;
  logic [IDW-1:0]   winner;
  logic [IDW-1:0]   scan_idx;
  logic [IDW+2:0]   byte_lsb;
  logic             timer_hit;

  // Bring tx_done/tx_err from the baud domain through flop chains.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      done_sync <= '0;
      err_sync  <= '0;
    end else begin
      done_sync <= {done_sync[SYNC_STAGES-2:0], bus.tx_done_i};
      err_sync  <= {err_sync[SYNC_STAGES-2:0], bus.tx_err_i};
    end
  end

  assign done_s = done_sync[SYNC_STAGES-1];
  assign err_s  = err_sync[SYNC_STAGES-1];

  // Round-robin pick: first requester found scanning upward from last+1.
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    scan_idx = '0;
    for (int i = 1; i <= NREQ; i++) begin
      scan_idx = IDW'((int'(last_q) + i) % NREQ);
      if (!found && bus.req_i[scan_idx]) begin
        found  = 1'b1;
        winner = scan_idx;
      end
    end
  end

  assign byte_lsb  = {winner, 3'b000};
  assign timer_inc = (timer_q == '1) ? timer_q : timer_q + 1'b1;
  assign timer_hit = (TIMEOUT != 0) && (timer_q == T_LAST);

  // Next-state and registered-output decode.
  always_comb begin
    state_nxt    = state_q;
    timer_nxt    = timer_q;
    last_nxt     = last_q;
    id_nxt       = id_q;
    sts_nxt      = sts_q;
    gnt_nxt      = '0;
    start_nxt    = start_q;
    data_nxt     = data_q;
    done_nxt     = 1'b0;
    done_id_nxt  = done_id_q;
    done_sts_nxt = done_sts_q;

    case (state_q)
      S_IDLE: begin
        // A done_s still high here is stale or stuck; granting now would
        // let the next SEND complete instantly on the old handshake.
        if (bus.en_i && found && !done_s) begin
          gnt_nxt[winner] = 1'b1;
          data_nxt        = bus.data_i[byte_lsb +: 8];
          id_nxt          = winner;
          last_nxt        = winner;
          sts_nxt         = 2'b00;
          start_nxt       = 1'b1;
          timer_nxt       = '0;
          state_nxt       = S_SEND;
        end
      end

      S_SEND: begin
        timer_nxt = timer_inc;
        if (done_s) begin
          sts_nxt   = err_s ? 2'b01 : 2'b00;
          start_nxt = 1'b0;
          timer_nxt = '0;
          state_nxt = S_RELEASE;
        end else if (timer_hit) begin
          sts_nxt   = 2'b10;
          start_nxt = 1'b0;
          timer_nxt = '0;
          state_nxt = S_RELEASE;
        end
      end

      S_RELEASE: begin
        timer_nxt = timer_inc;
        if (!done_s || timer_hit) begin
          done_nxt     = 1'b1;
          done_id_nxt  = id_q;
          // A clean SEND that never sees tx_done drop is still a timeout.
          done_sts_nxt = (done_s && sts_q == 2'b00) ? 2'b10 : sts_q;
          timer_nxt    = '0;
          state_nxt    = S_IDLE;
        end
      end

      default: begin
        start_nxt = 1'b0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any transfer silently.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      last_q     <= LAST_RST;
      id_q       <= '0;
      sts_q      <= 2'b00;
      gnt_q      <= '0;
      start_q    <= 1'b0;
      data_q     <= '0;
      done_q     <= 1'b0;
      done_id_q  <= '0;
      done_sts_q <= 2'b00;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      timer_q    <= timer_nxt;
      last_q     <= last_nxt;
      id_q       <= id_nxt;
      sts_q      <= sts_nxt;
      gnt_q      <= gnt_nxt;
      start_q    <= start_nxt;
      data_q     <= data_nxt;
      done_q     <= done_nxt;
      done_id_q  <= done_id_nxt;
      done_sts_q <= done_sts_nxt;
      busy_q     <= (state_nxt != S_IDLE);
    end
  end

  assign bus.gnt_o         = gnt_q;
  assign bus.busy_o        = busy_q;
  assign bus.done_o        = done_q;
  assign bus.done_id_o     = done_id_q;
  assign bus.done_status_o = done_sts_q;
  assign bus.tx_start_o    = start_q;
  assign bus.tx_data_o     = data_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: a behavioural uart_tx responder on its own
// time base, a round-robin expectation model, and one task per scenario.
module tb_uart_tx_arbiter;
  localparam int NREQ        = 4;
  localparam int TIMEOUT     = 100;
  localparam int SYNC_STAGES = 2;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   ref_last = NREQ - 1;
  int   uart_mode = 0;   // 0 normal, 1 never answers, 2 tx_done stuck high
  logic uart_err = 1'b0;
  logic [7:0] bytes [NREQ];

  uart_tx_arbiter_if #(.NREQ(NREQ)) bus ();

  uart_tx_arbiter #(
    .NREQ(NREQ),
    .TIMEOUT(TIMEOUT),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // uart_tx stand-in, ticking every 7 ns so it is asynchronous to clk.
  initial begin : uart_model
    int phase;
    int cnt;
    phase = 0;
    cnt = 0;
    bus.tx_done_i = 1'b0;
    bus.tx_err_i  = 1'b0;
    forever begin
      #7;
      if (rst_n !== 1'b1) begin
        phase = 0;
        bus.tx_done_i = 1'b0;
        bus.tx_err_i  = 1'b0;
      end else begin
        case (phase)
          0: if (bus.tx_start_o && uart_mode != 1) begin
               cnt = $urandom_range(2, 12);
               phase = 1;
             end
          1: if (cnt == 0) begin bus.tx_err_i = uart_err; phase = 2; end
             else cnt--;
          2: begin bus.tx_done_i = 1'b1; phase = 3; end
          3: if (!bus.tx_start_o && uart_mode != 2) begin
               cnt = $urandom_range(1, 8);
               phase = 4;
             end
          4: if (cnt == 0) begin bus.tx_done_i = 1'b0; phase = 5; end
             else cnt--;
          default: begin bus.tx_err_i = 1'b0; phase = 0; end
        endcase
      end
    end
  end

  initial begin : global_guard
    #3_000_000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1);
  end

  // Expected winner: first requesting index after the previous winner, cyclically.
  function automatic int predict(input int last, input logic [NREQ-1:0] mask);
    for (int k = 1; k <= NREQ; k++)
      if (mask[(last + k) % NREQ]) return (last + k) % NREQ;
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input int idx);
    logic [NREQ-1:0] v;
    v = '0;
    if (idx >= 0) v[idx] = 1'b1;
    return v;
  endfunction

  task automatic drive_req(input logic [NREQ-1:0] mask);
    for (int k = 0; k < NREQ; k++) bus.data_i[8*k +: 8] = bytes[k];
    bus.req_i = mask;
  endtask

  task automatic wait_gnt(input int budget, output logic seen, output int waited);
    seen = 1'b0;
    waited = 0;
    while (!seen && waited < budget) begin
      @(negedge clk);
      waited++;
      if (bus.gnt_o != '0) seen = 1'b1;
    end
  endtask

  task automatic wait_done(input int budget, output logic seen, output int waited);
    seen = 1'b0;
    waited = 0;
    while (!seen && waited < budget) begin
      @(negedge clk);
      waited++;
      if (bus.done_o) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.gnt_o, bus.busy_o, bus.done_o, bus.tx_start_o} !== '0) begin
      errors++;
      $display("FAIL reset_ctrl: gnt=%b busy=%b done=%b start=%b want all 0",
               bus.gnt_o, bus.busy_o, bus.done_o, bus.tx_start_o);
    end
    checks++;
    if ({bus.tx_data_o, bus.done_id_o, bus.done_status_o} !== '0) begin
      errors++;
      $display("FAIL reset_data: data=%h id=%0d status=%b want 0",
               bus.tx_data_o, bus.done_id_o, bus.done_status_o);
    end
    rst_n = 1'b1;
    ref_last = NREQ - 1;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.gnt_o, bus.busy_o, bus.tx_start_o} !== '0) begin
      errors++;
      $display("FAIL reset_idle: gnt=%b busy=%b start=%b want 0 with no requests",
               bus.gnt_o, bus.busy_o, bus.tx_start_o);
    end
  endtask

  task automatic test_back_to_back();
    int exp_id [5] = '{0, 1, 2, 3, 0};
    logic [7:0] exp_byte [5] = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h10};
    logic seen;
    int waited;
    bytes[0] = 8'h10; bytes[1] = 8'h21; bytes[2] = 8'h32; bytes[3] = 8'h43;
    drive_req(4'b1111);
    for (int k = 0; k < 5; k++) begin
      wait_gnt(40, seen, waited);
      checks++;
      if (!seen || bus.gnt_o !== onehot(exp_id[k])) begin
        errors++;
        $display("FAIL b2b_gnt%0d: gnt=%b want %b", k, bus.gnt_o, onehot(exp_id[k]));
      end
      if (k > 0) begin
        checks++;
        if (waited != 1) begin
          errors++;
          $display("FAIL b2b_latency%0d: grant %0d cycles after done, want 1", k, waited);
        end
      end
      checks++;
      if (bus.tx_data_o !== exp_byte[k]) begin
        errors++;
        $display("FAIL b2b_data%0d: tx_data=%h want %h", k, bus.tx_data_o, exp_byte[k]);
      end
      ref_last = exp_id[k];
      if (k == 4) drive_req('0);
      wait_done(400, seen, waited);
      checks++;
      if (!seen || bus.done_id_o !== 2'(exp_id[k]) || bus.done_status_o !== 2'b00) begin
        errors++;
        $display("FAIL b2b_done%0d: seen=%0b id=%0d status=%b want id %0d status 00",
                 k, seen, bus.done_id_o, bus.done_status_o, exp_id[k]);
      end
    end
    @(negedge clk);
    checks++;
    if (bus.done_o !== 1'b0 || bus.gnt_o !== '0) begin
      errors++;
      $display("FAIL b2b_tail: done=%b gnt=%b want 0 0", bus.done_o, bus.gnt_o);
    end
  endtask

  task automatic test_single();
    logic seen;
    int waited;
    bytes[0] = 8'hA5;
    drive_req(4'b0001);
    @(negedge clk);
    checks++;
    if (bus.gnt_o !== 4'b0001 || bus.tx_data_o !== 8'hA5 || bus.tx_start_o !== 1'b1 ||
        bus.busy_o !== 1'b1) begin
      errors++;
      $display("FAIL single_grant: gnt=%b data=%h start=%b busy=%b want 0001 a5 1 1",
               bus.gnt_o, bus.tx_data_o, bus.tx_start_o, bus.busy_o);
    end
    ref_last = predict(ref_last, 4'b0001);
    drive_req('0);
    @(negedge clk);
    checks++;
    if (bus.gnt_o !== '0 || bus.tx_start_o !== 1'b1) begin
      errors++;
      $display("FAIL single_pulse: gnt=%b start=%b want 0000 1", bus.gnt_o, bus.tx_start_o);
    end
    wait_done(300, seen, waited);
    checks++;
    if (!seen || bus.done_id_o !== 2'd0 || bus.done_status_o !== 2'b00 || bus.busy_o !== 1'b0) begin
      errors++;
      $display("FAIL single_done: seen=%0b id=%0d status=%b busy=%b want id 0 status 00 busy 0",
               seen, bus.done_id_o, bus.done_status_o, bus.busy_o);
    end
    @(negedge clk);
    checks++;
    if (bus.done_o !== 1'b0) begin
      errors++;
      $display("FAIL single_done_pulse: done=%b want 0 one cycle later", bus.done_o);
    end
  endtask

  task automatic test_uart_err();
    logic seen;
    int waited;
    for (int pass = 0; pass < 2; pass++) begin
      uart_err = (pass == 0);
      bytes[2] = 8'($urandom);
      drive_req(4'b0100);
      wait_gnt(20, seen, waited);
      checks++;
      if (!seen || bus.gnt_o !== 4'b0100 || bus.tx_data_o !== bytes[2]) begin
        errors++;
        $display("FAIL err_grant%0d: gnt=%b data=%h want 0100 %h",
                 pass, bus.gnt_o, bus.tx_data_o, bytes[2]);
      end
      ref_last = 2;
      drive_req('0);
      wait_done(300, seen, waited);
      checks++;
      if (!seen || bus.done_id_o !== 2'd2 || bus.done_status_o !== {1'b0, uart_err}) begin
        errors++;
        $display("FAIL err_status%0d: seen=%0b id=%0d status=%b want id 2 status %b",
                 pass, seen, bus.done_id_o, bus.done_status_o, {1'b0, uart_err});
      end
    end
    uart_err = 1'b0;
  endtask

  task automatic test_timeout();
    logic seen;
    int waited;
    int cyc;
    uart_mode = 1;
    bytes[1] = 8'($urandom);
    drive_req(4'b0010);
    wait_gnt(20, seen, waited);
    checks++;
    if (!seen || bus.gnt_o !== 4'b0010) begin
      errors++;
      $display("FAIL to_grant: gnt=%b want 0010", bus.gnt_o);
    end
    ref_last = 1;
    drive_req('0);
    cyc = 0;
    while (bus.tx_start_o && cyc < 3 * TIMEOUT) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc != TIMEOUT) begin
      errors++;
      $display("FAIL to_start_len: tx_start fell %0d cycles after grant, want %0d", cyc, TIMEOUT);
    end
    wait_done(10, seen, waited);
    checks++;
    if (!seen || waited > 3 || bus.done_id_o !== 2'd1 || bus.done_status_o !== 2'b10) begin
      errors++;
      $display("FAIL to_done: seen=%0b after %0d id=%0d status=%b want id 1 status 10",
               seen, waited, bus.done_id_o, bus.done_status_o);
    end
    uart_mode = 0;
    drive_req(4'b0010);
    wait_gnt(20, seen, waited);
    ref_last = 1;
    drive_req('0);
    wait_done(300, seen, waited);
    checks++;
    if (!seen || bus.done_status_o !== 2'b00) begin
      errors++;
      $display("FAIL to_recover: seen=%0b status=%b want 00", seen, bus.done_status_o);
    end
  endtask

  task automatic test_enable();
    logic seen;
    int waited;
    int ngnt;
    bus.en_i = 1'b0;
    bytes[2] = 8'($urandom);
    drive_req(4'b0100);
    ngnt = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (bus.gnt_o != '0 || bus.busy_o) ngnt++;
    end
    checks++;
    if (ngnt != 0) begin
      errors++;
      $display("FAIL en_block: %0d active cycles with en low, want 0", ngnt);
    end
    bus.en_i = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.gnt_o !== 4'b0100 || bus.tx_data_o !== bytes[2]) begin
      errors++;
      $display("FAIL en_resume: gnt=%b data=%h want 0100 %h", bus.gnt_o, bus.tx_data_o, bytes[2]);
    end
    ref_last = 2;
    drive_req('0);
    wait_done(300, seen, waited);
    checks++;
    if (!seen || bus.done_status_o !== 2'b00) begin
      errors++;
      $display("FAIL en_done: seen=%0b status=%b want 00", seen, bus.done_status_o);
    end
  endtask

  task automatic test_stuck_done();
    logic seen;
    int waited;
    int ngnt;
    uart_mode = 2;
    drive_req(4'b0001);
    wait_gnt(20, seen, waited);
    ref_last = 0;
    drive_req('0);
    wait_done(4 * TIMEOUT, seen, waited);
    checks++;
    if (!seen || bus.done_id_o !== 2'd0 || bus.done_status_o !== 2'b10) begin
      errors++;
      $display("FAIL stuck_release: seen=%0b id=%0d status=%b want id 0 status 10",
               seen, bus.done_id_o, bus.done_status_o);
    end
    bytes[2] = 8'($urandom);
    drive_req(4'b0100);
    ngnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.gnt_o != '0) ngnt++;
    end
    checks++;
    if (ngnt != 0) begin
      errors++;
      $display("FAIL stuck_block: %0d grants while tx_done stuck, want 0", ngnt);
    end
    uart_mode = 0;
    wait_gnt(30, seen, waited);
    checks++;
    if (!seen || bus.gnt_o !== 4'b0100 || bus.tx_data_o !== bytes[2]) begin
      errors++;
      $display("FAIL stuck_resume: gnt=%b data=%h want 0100 %h", bus.gnt_o, bus.tx_data_o, bytes[2]);
    end
    ref_last = 2;
    drive_req('0);
    wait_done(300, seen, waited);
    checks++;
    if (!seen || bus.done_status_o !== 2'b00) begin
      errors++;
      $display("FAIL stuck_after: seen=%0b status=%b want 00", seen, bus.done_status_o);
    end
  endtask

  task automatic test_random_traffic();
    logic [NREQ-1:0] pending;
    logic seen;
    int waited;
    int w;
    int k0;
    pending = '0;
    for (int t = 0; t < 24; t++) begin
      for (int k = 0; k < NREQ; k++)
        if (!pending[k] && $urandom_range(0, 1) == 1) begin
          pending[k] = 1'b1;
          bytes[k] = 8'($urandom);
        end
      if (pending == '0) begin
        k0 = $urandom_range(0, NREQ - 1);
        pending[k0] = 1'b1;
        bytes[k0] = 8'($urandom);
      end
      uart_err = ($urandom_range(0, 3) == 0);
      drive_req(pending);
      w = predict(ref_last, pending);
      wait_gnt(20, seen, waited);
      checks++;
      if (!seen || bus.gnt_o !== onehot(w) || bus.tx_data_o !== bytes[w]) begin
        errors++;
        $display("FAIL rand_grant%0d: gnt=%b data=%h want %b %h (pending %b)",
                 t, bus.gnt_o, bus.tx_data_o, onehot(w), bytes[w], pending);
      end
      ref_last = w;
      pending[w] = 1'b0;
      drive_req(pending);
      wait_done(300, seen, waited);
      checks++;
      if (!seen || bus.done_id_o !== 2'(w) || bus.done_status_o !== {1'b0, uart_err}) begin
        errors++;
        $display("FAIL rand_done%0d: seen=%0b id=%0d status=%b want id %0d status %b",
                 t, seen, bus.done_id_o, bus.done_status_o, w, {1'b0, uart_err});
      end
    end
    drive_req('0);
    uart_err = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic seen;
    int waited;
    int ndone;
    uart_mode = 1;
    drive_req(4'b0010);
    wait_gnt(20, seen, waited);
    drive_req('0);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.gnt_o, bus.busy_o, bus.done_o, bus.tx_start_o, bus.tx_data_o,
         bus.done_id_o, bus.done_status_o} !== '0) begin
      errors++;
      $display("FAIL rstmid_outputs: start=%b busy=%b data=%h done=%b want all 0",
               bus.tx_start_o, bus.busy_o, bus.tx_data_o, bus.done_o);
    end
    ref_last = NREQ - 1;
    uart_mode = 0;
    ndone = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus.done_o) ndone++;
    end
    rst_n = 1'b1;
    bytes[3] = 8'($urandom);
    drive_req(4'b1000);
    @(negedge clk);
    if (bus.done_o) ndone++;
    checks++;
    if (ndone != 0) begin
      errors++;
      $display("FAIL rstmid_nodone: %0d done pulses around reset, want 0", ndone);
    end
    checks++;
    if (bus.gnt_o !== onehot(predict(ref_last, 4'b1000)) || bus.tx_data_o !== bytes[3]) begin
      errors++;
      $display("FAIL rstmid_grant: gnt=%b data=%h want 1000 %h", bus.gnt_o, bus.tx_data_o, bytes[3]);
    end
    ref_last = 3;
    drive_req('0);
    wait_done(300, seen, waited);
    checks++;
    if (!seen || bus.done_id_o !== 2'd3 || bus.done_status_o !== 2'b00) begin
      errors++;
      $display("FAIL rstmid_done: seen=%0b id=%0d status=%b want id 3 status 00",
               seen, bus.done_id_o, bus.done_status_o);
    end
  endtask

  initial begin : main
    for (int k = 0; k < NREQ; k++) bytes[k] = 8'h00;
    bus.en_i   = 1'b1;
    bus.req_i  = '0;
    bus.data_i = '0;
    rst_n      = 1'b0;
    test_reset();
    test_back_to_back();
    test_single();
    test_uart_err();
    test_timeout();
    test_enable();
    test_stuck_done();
    test_random_traffic();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
